timer_irq: RTL and testbench
============================

TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 SHALL have parameter: PRE_W, 16, prescaler width in bits (1..16).
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: rd  input  1  bus read strobe, CPU peripheral region.
REQ-005 SHALL have port: wr  input  1  bus write strobe, CPU peripheral region.
REQ-006 SHALL have port: addr  input  32  byte address from CPU ALU result.
REQ-007 SHALL have port: wdata  input  32  store data from CPU register rt.
REQ-008 SHALL have port: rdata  output  32  load data to CPU; combinational.
REQ-009 SHALL have port: irqout  output  1  level interrupt request to CPU control.

Function
REQ-010 SHALL select a register only when addr[31:4] == 28'h4000000; addr[1:0] ignored.
REQ-011 SHALL map registers: 0x40000000 TH (reload), 0x40000004 TL (count), 0x40000008 TCON, 0x4000000C PRE.
REQ-012 SHALL define TCON bits: [0] run enable, [1] irq enable, [2] irq status; [31:3] read 0.
REQ-013 SHALL keep PRE as PRE_W bits; upper bits read 0, write-ignored.
REQ-014 SHALL drive rdata with the selected register when rd=1, else 32'h0; unmapped selects read 0.
REQ-015 SHALL write the selected register with wdata on the edge where wr=1; unmapped writes ignored.
REQ-016 SHALL hold an internal prescale counter pcnt (PRE_W bits), not bus-visible.
REQ-017 SHALL, while TCON[0]=1, emit a tick when pcnt == PRE, clearing pcnt; otherwise increment pcnt.
REQ-018 SHALL, with PRE=0, tick every cycle.
REQ-019 SHALL, while TCON[0]=0, hold pcnt and TL unchanged.
REQ-020 SHALL, on a tick, increment TL by 1 if TL != 32'hFFFFFFFF.
REQ-021 SHALL, on a tick with TL == 32'hFFFFFFFF, load TL <= TH and set TCON[2] <= 1 if TCON[1]=1.
REQ-022 SHALL give bus writes priority: TL write beats count/reload; TCON write beats status set in the same cycle.
REQ-023 SHALL make TCON[2] sticky; software clears it only by writing TCON with bit 2 = 0.
REQ-024 SHALL drive irqout = TCON[1] & TCON[2], registered-state based with no combinational path from bus inputs.
REQ-025 SHALL reset pcnt to 0 on any PRE write or on a TCON write that changes bit 0.
REQ-026 SHALL treat simultaneous rd and wr to the same register as returning the pre-write value on rdata.

Reset
REQ-027 SHALL, on reset=1 at a clk edge, clear TH, TL, TCON, PRE, and pcnt to 0.
REQ-028 SHALL hold irqout=0 during and after reset until status is set again.
REQ-029 SHALL make reset win over simultaneous wr and tick, discarding in-flight counting.
REQ-030 SHALL drive rdata from reset register values when rd=1 during reset.

Structure
REQ-031 SHALL place register offsets (TH/TL/TCON/PRE) and TCON bit indices in a shared package, also used by the peripheral decoder.
REQ-032 SHALL implement the prescaler as sub-module tick_gen (inputs: clk, reset, en, clr, pre; output: tick), with register file and TL/TH logic in timer_irq.

Verification
REQ-033 SHALL cover wrap: TH=0xFFFFFFFD, TL=0xFFFFFFFE, PRE=0, TCON=3 -> TL=0xFFFFFFFF after 1 cycle, TL=0xFFFFFFFD and irqout=1 after 2 cycles.
REQ-034 SHALL cover prescale: PRE=3, TL=0, TCON=1 -> TL increments once per 4 cycles; TL=5 after 20 cycles.
REQ-035 SHALL cover irq mask: wrap with TCON=1 -> TL reloads, TCON reads 1, irqout stays 0.
REQ-036 SHALL cover clear race: write TCON=3 on the same cycle as a wrap -> TCON reads 3 and irqout=0 next cycle.
REQ-037 SHALL cover decode: write 0x12345678 to 0x40000010 and 0x00000000 -> all registers unchanged; read 0x40000010 returns 0.
REQ-038 SHALL cover reset mid-count: reset=1 for 1 cycle while TCON=3, TL=0x100 -> all registers read 0, irqout=0, TL static.

Source files
------------

// File: rtl/timer_irq_pkg.sv
// -----------------------------------------------------------------------------
// timer_irq_pkg
// Shared definitions for the memory-mapped timer: base address, register
// offsets, TCON bit positions and small address-decode helpers. The CPU
// peripheral decoder imports this package so that both sides agree on the map.
// -----------------------------------------------------------------------------
package timer_irq_pkg;

  // Upper 28 address bits that select the timer block (0x4000_000x).
  localparam logic [27:0] TIMER_BASE_HI = 28'h4000000;

  // Byte offsets of the four word registers inside the block.
  localparam logic [3:0] OFF_TH   = 4'h0;
  localparam logic [3:0] OFF_TL   = 4'h4;
  localparam logic [3:0] OFF_TCON = 4'h8;
  localparam logic [3:0] OFF_PRE  = 4'hC;

  // TCON bit indices.
  localparam int TCON_RUN  = 0;
  localparam int TCON_IEN  = 1;
  localparam int TCON_STAT = 2;

  // Word select derived from the offsets (addr[1:0] is ignored).
  typedef enum logic [1:0] {
    REG_TH   = OFF_TH[3:2],
    REG_TL   = OFF_TL[3:2],
    REG_TCON = OFF_TCON[3:2],
    REG_PRE  = OFF_PRE[3:2]
  } timer_reg_e;

  function automatic logic timer_hit(input logic [31:0] a);
    return a[31:4] == TIMER_BASE_HI;
  endfunction

  function automatic timer_reg_e timer_reg(input logic [31:0] a);
    return timer_reg_e'(a[3:2]);
  endfunction

endpackage

// File: rtl/timer_irq_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler for the timer. While en=1 it counts pcnt up to pre and emits a
// one-cycle tick on the cycle where pcnt == pre, then restarts from 0, giving
// one tick every pre+1 cycles (every cycle when pre=0). While en=0 the count
// holds. clr restarts the count from 0.
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   en     run enable (TCON run bit)
//   clr    restart prescale count
//   pre    prescale terminal value
//   tick   count-enable pulse for the timer counter
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);

  logic [PRE_W-1:0] pcnt;

  // Driven only from registered state, so no bus input reaches tick directly.
  assign tick = en && (pcnt == pre);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_irq.sv
// -----------------------------------------------------------------------------
// timer_irq
// Memory-mapped 32-bit timer with prescaler and sticky interrupt status.
//   0x4000_0000 TH   reload value
//   0x4000_0004 TL   counter; counts up on each prescaler tick and reloads
//                    from TH after reaching 0xFFFF_FFFF
//   0x4000_0008 TCON [0] run, [1] irq enable, [2] irq status (sticky)
//   0x4000_000C PRE  prescale value, PRE_W bits
// Bus writes win over hardware updates of the same register in a cycle.
//
// Ports:
//   clk     system clock
//   reset   synchronous active-high reset
//   rd, wr  bus read / write strobes
//   addr    byte address
//   wdata   write data
//   rdata   combinational read data (0 when not reading a timer register)
//   irqout  level interrupt, irq enable AND irq status
// -----------------------------------------------------------------------------
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter int PRE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout
);

  logic [31:0]      th;
  logic [31:0]      tl;
  logic [2:0]       tcon;
  logic [PRE_W-1:0] pre;

  logic       sel;
  timer_reg_e reg_sel;
  logic       wr_th, wr_tl, wr_tcon, wr_pre;
  logic       tick, tl_max, wrap, pcnt_clr;
  logic       unused_addr_bits;

  assign sel     = timer_hit(addr);
  assign reg_sel = timer_reg(addr);

  assign wr_th   = wr && sel && (reg_sel == REG_TH);
  assign wr_tl   = wr && sel && (reg_sel == REG_TL);
  assign wr_tcon = wr && sel && (reg_sel == REG_TCON);
  assign wr_pre  = wr && sel && (reg_sel == REG_PRE);

  // Byte lanes are not decoded; word accesses only.
  assign unused_addr_bits = ^addr[1:0];

  assign tl_max = &tl;
  assign wrap   = tick && tl_max;

  // Restart the prescaler whenever its period or the run state changes so the
  // first tick after a reconfiguration arrives a full period later.
  assign pcnt_clr = wr_pre || (wr_tcon && (wdata[TCON_RUN] != tcon[TCON_RUN]));

  tick_gen #(
    .PRE_W (PRE_W)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (tcon[TCON_RUN]),
    .clr   (pcnt_clr),
    .pre   (pre),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      pre  <= '0;
    end else begin
      if (wr_th) th <= wdata;

      if (wr_tl)     tl <= wdata;
      else if (tick) tl <= tl_max ? th : tl + 32'd1;

      if (wr_pre) pre <= wdata[PRE_W-1:0];

      // Software writes the whole field, so writing status=0 clears it even
      // when a wrap lands in the same cycle.
      if (wr_tcon) tcon <= wdata[2:0];
      else if (wrap && tcon[TCON_IEN]) tcon[TCON_STAT] <= 1'b1;
    end
  end

  // NOTE: rdata gets a default before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    rdata = '0;
    if (rd && sel) begin
      unique case (reg_sel)
        REG_TH:   rdata = th;
        REG_TL:   rdata = tl;
        REG_TCON: rdata = {29'd0, tcon};
        REG_PRE:  rdata = {{(32-PRE_W){1'b0}}, pre};
      endcase
    end
  end

  assign irqout = tcon[TCON_IEN] & tcon[TCON_STAT];

endmodule

// File: tb/tb_timer_irq.sv
module tb_timer_irq;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_PRE  = 32'h4000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irqout;

  int n_checks = 0;
  int n_errors = 0;

  timer_irq #(.PRE_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irqout (irqout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock edge; returns in the low phase after it.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    step();
    wr = 1'b0;
  endtask

  // Combinational read within the current low phase (no clock edge).
  task automatic check_reg(input logic [31:0] a, input logic [31:0] exp, input string name);
    rd = 1'b1; addr = a;
    #1;
    check(name, rdata, exp);
    rd = 1'b0;
  endtask

  task automatic check_irq(input logic exp, input string name);
    check(name, {31'd0, irqout}, {31'd0, exp});
  endtask

  initial begin
    // ----- register access / decode table, timer stopped -----
    vecs.push_back('{1'b1, 1'b0, A_TH,          32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, A_TL,          32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, A_TCON,        32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, A_PRE,         32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b0, 1'b1, A_TH,          32'hA5A5A5A5,  32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, A_TH,          32'h0,         32'hA5A5A5A5,  1'b0});
    vecs.push_back('{1'b0, 1'b1, A_PRE,         32'hFFFF1234,  32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, A_PRE,         32'h0,         32'h00001234,  1'b0});
    vecs.push_back('{1'b0, 1'b1, A_TCON,        32'hFFFFFFF8,  32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, A_TCON,        32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b0, 1'b1, A_TCON,        32'h6,         32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, A_TCON,        32'h0,         32'h6,         1'b1});
    vecs.push_back('{1'b0, 1'b1, A_TCON,        32'h0,         32'h0,         1'b1});
    vecs.push_back('{1'b1, 1'b0, A_TCON,        32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b1, A_TH,          32'h11111111,  32'hA5A5A5A5,  1'b0});
    vecs.push_back('{1'b1, 1'b0, A_TH,          32'h0,         32'h11111111,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h40000010,  32'h12345678,  32'h0,         1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h00000000,  32'h12345678,  32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h40000010,  32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h40000005,  32'h00000077,  32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h40000007,  32'h0,         32'h00000077,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h40000002,  32'h0,         32'h11111111,  1'b0});
    vecs.push_back('{1'b1, 1'b0, A_TCON,        32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, A_PRE,         32'h0,         32'h00001234,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h00000000,  32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b0, 1'b0, A_TH,          32'h0,         32'h0,         1'b0});

    @(negedge clk);
    do_reset();

    foreach (vecs[i]) begin
      rd = vecs[i].rd; wr = vecs[i].wr; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_irq", i), {31'd0, irqout}, {31'd0, vecs[i].exp_irq});
      step();
      rd = 1'b0; wr = 1'b0;
    end

    // ----- wrap with interrupt, then status-clear race -----
    do_reset();
    check_irq(1'b0, "reset_irq");
    write_reg(A_TH, 32'hFFFFFFFD);
    write_reg(A_TL, 32'hFFFFFFFE);
    write_reg(A_PRE, 32'h0);
    write_reg(A_TCON, 32'h3);
    step();
    check_reg(A_TL, 32'hFFFFFFFF, "wrap_tl_1");
    check_irq(1'b0, "wrap_irq_1");
    step();
    check_reg(A_TL, 32'hFFFFFFFD, "wrap_tl_2");
    check_reg(A_TCON, 32'h7, "wrap_tcon_2");
    check_irq(1'b1, "wrap_irq_2");
    step();
    step();
    check_reg(A_TL, 32'hFFFFFFFF, "race_tl_pre");
    write_reg(A_TCON, 32'h3);
    check_reg(A_TCON, 32'h3, "race_tcon");
    check_reg(A_TL, 32'hFFFFFFFD, "race_tl_reload");
    check_irq(1'b0, "race_irq");

    // ----- wrap with interrupt masked -----
    do_reset();
    write_reg(A_TH, 32'h55);
    write_reg(A_TL, 32'hFFFFFFFF);
    write_reg(A_TCON, 32'h1);
    step();
    check_reg(A_TL, 32'h55, "mask_tl");
    check_reg(A_TCON, 32'h1, "mask_tcon");
    check_irq(1'b0, "mask_irq");
    step();
    check_reg(A_TL, 32'h56, "mask_tl_next");

    // ----- prescale by 4, then stop -----
    do_reset();
    write_reg(A_PRE, 32'h3);
    write_reg(A_TL, 32'h0);
    write_reg(A_TCON, 32'h1);
    repeat (3) step();
    check_reg(A_TL, 32'h0, "pre_tl_3");
    step();
    check_reg(A_TL, 32'h1, "pre_tl_4");
    repeat (15) step();
    check_reg(A_TL, 32'h4, "pre_tl_19");
    step();
    check_reg(A_TL, 32'h5, "pre_tl_20");
    write_reg(A_TCON, 32'h0);
    repeat (5) step();
    check_reg(A_TL, 32'h5, "stop_tl_hold");

    // ----- reset while counting -----
    do_reset();
    write_reg(A_TH, 32'h10);
    write_reg(A_TL, 32'h100);
    write_reg(A_TCON, 32'h3);
    step();
    step();
    check_reg(A_TL, 32'h102, "rst_tl_pre");
    do_reset();
    check_reg(A_TH, 32'h0, "rst_th");
    check_reg(A_TL, 32'h0, "rst_tl");
    check_reg(A_TCON, 32'h0, "rst_tcon");
    check_reg(A_PRE, 32'h0, "rst_pre");
    check_irq(1'b0, "rst_irq");
    repeat (3) step();
    check_reg(A_TL, 32'h0, "rst_tl_static");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
